// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flip-flop add two
// WIDTH-bit operands LSB-first, then present the parallel sum with a done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             sum_bit,
  output logic             sum_bit_valid,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] res_shift;
  logic             last_step;

  // The single full-adder cell shared by every bit position.
  assign s_bit     = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign res_shift = {s_bit, res_q[WIDTH-1:1]};
  assign last_step = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operands are only captured in IDLE, so a start held during RUN/DONE is inert.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = carry_nxt;
        res_d   = res_shift;
        cnt_d   = cnt_q + 1'b1;
        if (last_step) begin
          sum_d  = res_shift;
          cout_d = carry_nxt;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    sum_bit       = 1'b0;
    sum_bit_valid = 1'b0;
    unique case (state_q)
      RUN: begin
        busy          = 1'b1;
        sum_bit       = s_bit;
        sum_bit_valid = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=8 and WIDTH=16: directed cases plus random
// operations, checked by a done-triggered monitor against a + b + cin.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // ---------------- WIDTH = 8 instance ----------------
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        cin8 = 1'b0;
  logic        busy8, done8, cout8, sb8, sbv8;
  logic [7:0]  sum8;
  logic [1:0]  st8;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .sum_bit(sb8), .sum_bit_valid(sbv8), .state_dbg(st8)
  );

  // ---------------- WIDTH = 16 instance ----------------
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        cin16 = 1'b0;
  logic        busy16, done16, cout16, sb16, sbv16;
  logic [15:0] sum16;
  logic [1:0]  st16;

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16),
    .sum_bit(sb16), .sum_bit_valid(sbv16), .state_dbg(st16)
  );

  // Expected {cout, sum} per accepted operation, oldest first.
  logic [8:0]  exp8_q[$];
  logic [16:0] exp16_q[$];
  logic [8:0]  held8 = '0;
  logic [16:0] held16 = '0;
  logic [7:0]  stream8 = '0;
  logic [15:0] stream16 = '0;
  int          nbits8 = 0, nbits16 = 0;
  logic        prev_done8 = 1'b0, prev_done16 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  logic [8:0] e8;
  always @(negedge clk) begin
    if (rst_n) begin
      if (sbv8) begin
        stream8 = {sb8, stream8[7:1]};
        nbits8++;
      end else begin
        chk("w8_sum_bit_idle_zero", 32'(sb8), 32'd0);
      end
      if (done8) begin
        chk("w8_done_one_cycle", 32'(prev_done8), 32'd0);
        if (exp8_q.size() == 0) begin
          chk("w8_unexpected_done", 32'(done8), 32'd0);
        end else begin
          e8 = exp8_q.pop_front();
          chk("w8_result", 32'({cout8, sum8}), 32'(e8));
          chk("w8_stream", 32'({nbits8[7:0], stream8}), 32'({8'd8, e8[7:0]}));
          held8 = e8;
        end
        nbits8 = 0;
      end else begin
        chk("w8_result_held", 32'({cout8, sum8}), 32'(held8));
      end
      prev_done8 = done8;
    end
  end

  logic [16:0] e16;
  always @(negedge clk) begin
    if (rst_n) begin
      if (sbv16) begin
        stream16 = {sb16, stream16[15:1]};
        nbits16++;
      end else begin
        chk("w16_sum_bit_idle_zero", 32'(sb16), 32'd0);
      end
      if (done16) begin
        chk("w16_done_one_cycle", 32'(prev_done16), 32'd0);
        if (exp16_q.size() == 0) begin
          chk("w16_unexpected_done", 32'(done16), 32'd0);
        end else begin
          e16 = exp16_q.pop_front();
          chk("w16_result", 32'({cout16, sum16}), 32'(e16));
          chk("w16_stream", 32'({nbits16[7:0], stream16}), 32'({8'd16, e16[15:0]}));
          held16 = e16;
        end
        nbits16 = 0;
      end else begin
        chk("w16_result_held", 32'({cout16, sum16}), 32'(held16));
      end
      prev_done16 = done16;
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_idle8();
    int n = 0;
    @(negedge clk);
    while (busy8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy8) chk("w8_idle_timeout", 32'(busy8), 32'd0);
  endtask

  task automatic wait_idle16();
    int n = 0;
    @(negedge clk);
    while (busy16 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy16) chk("w16_idle_timeout", 32'(busy16), 32'd0);
  endtask

  // Issue one op; optionally wiggle start with junk operands during RUN.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic junk);
    wait_idle8();
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    exp8_q.push_back({1'b0, a} + {1'b0, b} + 9'(c));
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    if (junk) begin
      start8 = 1'b1;
      repeat (2) @(posedge clk);
      #1 start8 = 1'b0;
    end
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic junk);
    wait_idle16();
    a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
    exp16_q.push_back({1'b0, a} + {1'b0, b} + 17'(c));
    @(posedge clk); #1;
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    if (junk) begin
      start16 = 1'b1;
      repeat (3) @(posedge clk);
      #1 start16 = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp8_q.size() != 0 || exp16_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending_ops", 32'(exp8_q.size() + exp16_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic rand8();
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end
  endtask

  task automatic rand16();
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  logic [7:0] exp_bits;
  int         n;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_w8", 32'({busy8, done8, sb8, sbv8, cout8, sum8}), 32'd0);
    chk("reset_outputs_w16", 32'({busy16, done16, sb16, sbv16, cout16, sum16}), 32'd0);
    rst_n = 1'b1;

    // Serial stream and latency for 3C + 5A.
    issue8(8'h3C, 8'h5A, 1'b0, 1'b0);
    exp_bits = 8'h96;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("stream_bit", 32'(sb8), 32'(exp_bits[k]));
      chk("stream_valid", 32'({sbv8, busy8, done8}), 32'b110);
    end
    @(negedge clk);
    chk("done_latency", 32'({done8, busy8}), 32'b11);
    @(negedge clk);
    chk("idle_after_done", 32'(busy8), 32'd0);

    // Carry boundaries.
    issue8(8'hFF, 8'h01, 1'b0, 1'b0);
    issue8(8'hFF, 8'hFF, 1'b1, 1'b0);
    drain();

    // start held through RUN/DONE: second op accepted only once back in IDLE.
    wait_idle8();
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    exp8_q.push_back(9'h002);
    @(posedge clk); #1;
    a8 = 8'hAA; b8 = 8'h11;
    n = 0;
    do begin @(negedge clk); n++; end while (!done8 && n < 40);
    chk("hold_start_done_latency", 32'(n), 32'd9);
    exp8_q.push_back(9'h0BB);
    @(negedge clk);
    chk("hold_start_idle_gap", 32'(busy8), 32'd0);
    @(posedge clk); #1 start8 = 1'b0;
    drain();

    // Result holds through the next RUN.
    issue8(8'h10, 8'h20, 1'b0, 1'b0);
    issue8(8'h05, 8'h06, 1'b0, 1'b0);
    drain();

    // Reset mid-RUN discards the partial result.
    issue8(8'h03, 8'h04, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    exp8_q.delete();
    held8 = '0; nbits8 = 0; prev_done8 = 1'b0;
    #1;
    chk("midrun_reset_outputs", 32'({busy8, done8, sb8, sbv8, cout8, sum8}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue8(8'h07, 8'h08, 1'b0, 1'b0);
    drain();

    fork
      rand8();
      rand16();
    join
    drain();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
